// File: rtl/gain_arb_if.sv
// Handshake bundle between gain_arb and its surrounding FIFOs.
// master = arbiter side, slave = FIFO/core side.
interface gain_arb_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in0_empty;
   logic                  in0_rd_en;
   logic [DATA_WIDTH-1:0] in0_dout;
   logic                  in1_empty;
   logic                  in1_rd_en;
   logic [DATA_WIDTH-1:0] in1_dout;
   logic                  core_full;
   logic                  core_wr_en;
   logic [DATA_WIDTH-1:0] core_din;
   logic                  core_empty;
   logic                  core_rd_en;
   logic [DATA_WIDTH-1:0] core_dout;
   logic                  out0_full;
   logic                  out0_wr_en;
   logic [DATA_WIDTH-1:0] out0_din;
   logic                  out1_full;
   logic                  out1_wr_en;
   logic [DATA_WIDTH-1:0] out1_din;

   modport master (
      input  in0_empty, in0_dout,
      input  in1_empty, in1_dout,
      input  core_full, core_empty, core_dout,
      input  out0_full, out1_full,
      output in0_rd_en, in1_rd_en,
      output core_wr_en, core_din, core_rd_en,
      output out0_wr_en, out0_din,
      output out1_wr_en, out1_din
   );

   modport slave (
      output in0_empty, in0_dout,
      output in1_empty, in1_dout,
      output core_full, core_empty, core_dout,
      output out0_full, out1_full,
      input  in0_rd_en, in1_rd_en,
      input  core_wr_en, core_din, core_rd_en,
      input  out0_wr_en, out0_din,
      input  out1_wr_en, out1_din
   );
endinterface

// File: rtl/gain_arb.sv
// Two-channel round-robin front end for one shared in-order gain core.
// Only channel tags are kept; results are steered by the oldest tag.
module gain_arb #(
   parameter  int DATA_WIDTH = 32,
   parameter  int TAG_DEPTH  = 8,
   localparam int CW         = $clog2(TAG_DEPTH) + 1,
   localparam int AW         = $clog2(TAG_DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   gain_arb_if.master    bus,
   input  logic          drain,
   output logic          drain_done,
   output logic [CW-1:0] in_flight,
   output logic          err
);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t        state;
   logic          last;
   logic          tags [TAG_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   logic has_tag;
   logic head;
   logic ret;
   logic room;
   logic el0;
   logic el1;
   logic iss;
   logic gnt;

   assign has_tag = (in_flight != '0);
   assign head    = tags[rd_ptr];

   assign ret = !reset && !bus.core_empty && has_tag &&
                !(head ? bus.out1_full : bus.out0_full);

   // A return in the same cycle frees a slot for a new issue.
   assign room = (in_flight < CW'(TAG_DEPTH)) || ret;

   assign el0 = !reset && (state == RUN) && !bus.in0_empty &&
                !bus.core_full && room;
   assign el1 = !reset && (state == RUN) && !bus.in1_empty &&
                !bus.core_full && room;

   assign iss = el0 | el1;
   assign gnt = (el0 && el1) ? !last : el1;

   assign bus.in0_rd_en  = iss && !gnt;
   assign bus.in1_rd_en  = iss && gnt;
   assign bus.core_wr_en = iss;
   assign bus.core_din   = gnt ? bus.in1_dout : bus.in0_dout;

   assign bus.core_rd_en = ret;
   assign bus.out0_wr_en = ret && !head;
   assign bus.out1_wr_en = ret && head;
   assign bus.out0_din   = bus.core_dout;
   assign bus.out1_din   = bus.core_dout;

   assign drain_done = (state == DRAIN) && !has_tag;

   always_ff @(posedge clock) begin
      if (!reset && iss)
         tags[wr_ptr] <= gnt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= RUN;
         last      <= 1'b1;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         in_flight <= '0;
         err       <= 1'b0;
      end else begin
         if (iss) begin
            wr_ptr <= wr_ptr + 1'b1;
            last   <= gnt;
         end
         if (ret)
            rd_ptr <= rd_ptr + 1'b1;
         in_flight <= in_flight + CW'(iss) - CW'(ret);
         // Core produced data nobody asked for.
         if (!bus.core_empty && !has_tag)
            err <= 1'b1;
         unique case (state)
            RUN:
               if (drain)
                  state <= DRAIN;
            DRAIN:
               if (!drain && !has_tag)
                  state <= RUN;
            default:
               state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_gain_arb.sv
// Randomized bench for gain_arb with a queue-based model of tags,
// the shared core and the round-robin rule.
module tb_gain_arb;

   localparam int DW = 32;
   localparam int TD = 8;
   localparam int CW = $clog2(TD) + 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          drain;
   logic          drain_done;
   logic [CW-1:0] in_flight;
   logic          err;

   gain_arb_if #(.DATA_WIDTH(DW)) bus ();

   gain_arb #(
      .DATA_WIDTH(DW),
      .TAG_DEPTH (TD)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .drain     (drain),
      .drain_done(drain_done),
      .in_flight (in_flight),
      .err       (err)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   bit            tagq [$];
   logic [DW-1:0] coreq [$];
   bit            last;
   bit            mdrain;
   bit            merr;
   logic [DW-1:0] cur0;
   logic [DW-1:0] cur1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] gainf(input logic [DW-1:0] x);
      return x * 3 + 1;
   endfunction

   task automatic step(input bit rst, input int p_in, input int p_full,
                       input int p_ret, input int p_sink,
                       input int p_drain, input bit force_ce);
      bit ce;
      bit hd;
      bit rt;
      bit room;
      bit e0;
      bit e1;
      bit is;
      bit g;
      int sz;
      @(negedge clock);
      reset          = rst;
      bus.in0_empty  = !($urandom_range(99) < p_in);
      bus.in1_empty  = !($urandom_range(99) < p_in);
      bus.in0_dout   = cur0;
      bus.in1_dout   = cur1;
      bus.core_full  = ($urandom_range(99) < p_full);
      ce = !(coreq.size() > 0 && $urandom_range(99) < p_ret);
      if (force_ce)
         ce = 1'b0;
      bus.core_empty = ce;
      bus.core_dout  = (coreq.size() > 0) ? gainf(coreq[0]) : $urandom;
      bus.out0_full  = ($urandom_range(99) < p_sink);
      bus.out1_full  = ($urandom_range(99) < p_sink);
      drain          = ($urandom_range(99) < p_drain);
      #1;
      if (rst) begin
         chk("rst_in0_rd", bus.in0_rd_en, 0);
         chk("rst_in1_rd", bus.in1_rd_en, 0);
         chk("rst_core_wr", bus.core_wr_en, 0);
         chk("rst_core_rd", bus.core_rd_en, 0);
         chk("rst_out0_wr", bus.out0_wr_en, 0);
         chk("rst_out1_wr", bus.out1_wr_en, 0);
         tagq.delete();
         coreq.delete();
         last   = 1'b1;
         mdrain = 1'b0;
         merr   = 1'b0;
         return;
      end
      sz   = tagq.size();
      hd   = (sz > 0) ? tagq[0] : 1'b0;
      rt   = !ce && sz > 0 &&
             !(hd ? bus.out1_full : bus.out0_full);
      room = (sz < TD) || rt;
      e0   = !mdrain && !bus.in0_empty && !bus.core_full && room;
      e1   = !mdrain && !bus.in1_empty && !bus.core_full && room;
      is   = e0 || e1;
      g    = (e0 && e1) ? !last : e1;
      chk("in_flight", in_flight, sz);
      chk("err", err, merr);
      chk("drain_done", drain_done, mdrain && sz == 0);
      chk("core_wr_en", bus.core_wr_en, is);
      chk("in0_rd_en", bus.in0_rd_en, is && !g);
      chk("in1_rd_en", bus.in1_rd_en, is && g);
      if (is)
         chk("core_din", bus.core_din, g ? cur1 : cur0);
      chk("core_rd_en", bus.core_rd_en, rt);
      chk("out0_wr_en", bus.out0_wr_en, rt && !hd);
      chk("out1_wr_en", bus.out1_wr_en, rt && hd);
      if (rt && !hd)
         chk("out0_din", bus.out0_din, gainf(coreq[0]));
      if (rt && hd)
         chk("out1_din", bus.out1_din, gainf(coreq[0]));
      if (!ce && sz == 0)
         merr = 1'b1;
      if (!mdrain && drain)
         mdrain = 1'b1;
      else if (mdrain && !drain && sz == 0)
         mdrain = 1'b0;
      if (rt) begin
         void'(tagq.pop_front());
         void'(coreq.pop_front());
      end
      if (is) begin
         coreq.push_back(g ? cur1 : cur0);
         tagq.push_back(g);
         last = g;
         if (g)
            cur1 = $urandom;
         else
            cur0 = $urandom;
      end
   endtask

   initial begin
      reset = 1'b1;
      drain = 1'b0;
      cur0  = $urandom;
      cur1  = $urandom;
      repeat (2) step(1, 0, 0, 0, 0, 0, 0);
      // Alternating grants with everything ready.
      repeat (16) step(0, 100, 0, 100, 0, 0, 0);
      // Core stalls: fill to TAG_DEPTH and stop.
      repeat (14) step(0, 100, 0, 0, 0, 0, 0);
      @(posedge clock);
      #1 chk("fill_cnt", in_flight, TD);
      // Return and issue together at full.
      step(0, 100, 0, 100, 0, 0, 0);
      @(posedge clock);
      #1 chk("full_swap_cnt", in_flight, TD);
      // Random traffic with drains and a mid-run reset.
      for (int i = 0; i < 800; i++) begin
         if (i == 400)
            step(1, 50, 0, 50, 0, 0, 0);
         else
            step(0, 70, 20, 60, 30, 3, 0);
      end
      // Let drain finish and the pipeline empty out.
      repeat (40) step(0, 0, 0, 100, 0, 0, 0);
      // Spurious core data after reset.
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 1);
      @(posedge clock);
      #1 chk("err_set", err, 1);
      step(1, 0, 0, 0, 0, 0, 0);
      @(posedge clock);
      #1 chk("err_clr", err, 0);
      repeat (4) step(0, 100, 0, 100, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
